issue_scheduler: RTL
====================

# issue_scheduler

Out-of-order issue queue that sits directly upstream of register read. It accepts one dispatched `disp_packet_t` per cycle and tracks source-operand readiness per entry via physical-register wakeup broadcasts. Each cycle it selects the oldest ready entry and fires it to register read as `sched_pkt` / `fire_valid`. Fire and wakeup timing allow dependent single-cycle ops to issue back-to-back, with the forwarding unit supplying operands.

## Interface
- `DEPTH`, 8, number of queue entries (power of 2, ≥2)
- `PREG_W`, 6, physical register tag width
- `WAKE_PORTS`, 2, external wakeup broadcast ports
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, reset is asynchronous and active-low
- `flush`  in  1  synchronous squash of all entries
- `disp_valid`  in  1  dispatch request
- `disp_pkt`  in  disp_packet_t  packet to enqueue (`dst_preg`, `src1_preg`, `src2_preg`, `imm_val`, `instr_valid`, `pc`)
- `disp_src1_rdy`, `disp_src2_rdy`  in  1 each  busy-table readiness at dispatch
- `disp_ready`  out  1  at least one free entry
- `wake_valid`  in  WAKE_PORTS  wakeup strobe per port
- `wake_preg`  in  WAKE_PORTS×PREG_W  tag being produced per port
- `fire_valid`  out  1  registered; `sched_pkt` is valid
- `sched_pkt`  out  disp_packet_t  registered issued packet
- `occupancy`  out  $clog2(DEPTH+1)  valid entry count

## Operation
- Each entry holds: `valid`, the packet, `src1_rdy`, `src2_rdy`, and an age row of DEPTH bits. A set bit j in row i means entry j is older than i.
- Allocation happens when `disp_valid && disp_ready`. The pkt goes to the lowest-index invalid entry.
  - Its age row is set to the current `valid` vector, excluding any entry leaving this cycle.
  - Other entries clear their column bit for any entry leaving this cycle.
- `disp_valid` while `!disp_ready` is ignored. No state changes.
- A source is ready at allocation if any of the following holds:
  - its `disp_srcN_rdy` is 1;
  - its tag == 0 (preg 0 is the constant zero);
  - it matches a same-cycle `wake_preg` with `wake_valid` set;
  - it matches the `dst_preg` of the entry selected this cycle.
- Wakeup: each valid entry sets `srcN_rdy` on a tag match with any valid wake port, or with the selected entry's `dst_preg` when `dst_preg != 0` (internal wakeup). Ready bits never clear while the entry is valid.
- Selection is combinational over the current state.
  - Eligible = `valid && src1_rdy && src2_rdy`, using registered bits only. An entry allocated in cycle N is first eligible in N+1.
  - Winner = the eligible entry with no eligible older entry, found by AND of its age row with the eligible vector == 0.
  - At most one winner per cycle. The winner's entry is freed at the clock edge.
- Outputs at the edge:
  - with a winner: `fire_valid<=1`, `sched_pkt<=`winner pkt;
  - with no winner: `fire_valid<=0` and `sched_pkt` holds its old value.
- `disp_ready` = any entry invalid in the registered state. It is combinational from state only. A same-cycle fire does not free a slot for same-cycle dispatch.
- `occupancy` is the registered popcount of `valid`. It updates +1 on alloc and −1 on fire, with net 0 when both happen.
- `flush`:
  - at the edge, all `valid<=0` and `fire_valid<=0`;
  - any same-cycle dispatch and fire are discarded;
  - flush has priority over everything except `rst`.
- Reset (async, `rst`=0):
  - all `valid`, ready bits and age rows = 0;
  - `fire_valid`=0, `sched_pkt`='0, `occupancy`=0;
  - `disp_ready`=1 after release.
  - Reset mid-operation drops all entries immediately.

## Timing
- Dispatch to fire, with ready sources: alloc at edge N, selected in N+1, `fire_valid` high in cycle N+2.
- Wakeup to fire: a wake strobe in cycle N makes an entry eligible in N+1, and it fires visibly in N+2.
- Back-to-back dependents:
  - producer selected in N, visible N+1;
  - consumer woken at edge N, selected N+1, visible N+2, with no bubble.
- The issue rate is at most one per cycle. Register read consumes every fire, so there is no downstream stall.
- A full queue with no ready entry deadlocks until a wakeup arrives. That is legal.

## Test plan
- Reset: assert `rst`=0 mid-run with 3 entries → `fire_valid`=0, `occupancy`=0, `disp_ready`=1; no fire after release.
- Single op: dispatch pc=0x100, both srcs rdy, at cycle 0 → `fire_valid`=1 with `sched_pkt.pc`=0x100 in cycle 2 only; `occupancy` goes 0,1,0.
- Chain: A (dst p5, srcs rdy) and then B (src1 p5 not rdy) dispatched consecutively → A and B fire in consecutive cycles, A first.
- Age order: dispatch X (src1 p9 not rdy), then ready Y, then ready Z; pulse `wake_preg`=9 before Y fires → fire order Y, X, Z; X is older than Z.
- Full: 8 dispatches, all waiting on p12 → `disp_ready`=0 and a 9th dispatch is dropped; wake p12 → 8 fires in dispatch order, and `disp_ready`=1 the cycle after the first fire.
- Flush: 4 ready entries, `flush` during the first select → no `fire_valid` the next cycle, `occupancy`=0; a dispatch during flush is not enqueued.

Source files
------------

// File: rtl/issue_scheduler_if.sv
// Dispatch packet type and the dispatch/wakeup/issue bundle that connects
// the issue scheduler to rename/dispatch and register read.
package issue_scheduler_pkg;
    localparam int unsigned PREG_W = 6;
    localparam int unsigned XLEN   = 32;

    typedef struct packed {
        logic [PREG_W-1:0] dst_preg;
        logic [PREG_W-1:0] src1_preg;
        logic [PREG_W-1:0] src2_preg;
        logic [XLEN-1:0]   imm_val;
        logic              instr_valid;
        logic [XLEN-1:0]   pc;
    } disp_packet_t;
endpackage

interface issue_scheduler_if #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WAKE_PORTS = 2
) ();
    import issue_scheduler_pkg::*;

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic                                flush;
    logic                                disp_valid;
    disp_packet_t                        disp_pkt;
    logic                                disp_src1_rdy;
    logic                                disp_src2_rdy;
    logic                                disp_ready;
    logic [WAKE_PORTS-1:0]               wake_valid;
    logic [WAKE_PORTS-1:0][PREG_W-1:0]   wake_preg;
    logic                                fire_valid;
    disp_packet_t                        sched_pkt;
    logic [OCC_W-1:0]                    occupancy;

    modport master (
        output flush, disp_valid, disp_pkt, disp_src1_rdy, disp_src2_rdy,
        output wake_valid, wake_preg,
        input  disp_ready, fire_valid, sched_pkt, occupancy
    );

    modport slave (
        input  flush, disp_valid, disp_pkt, disp_src1_rdy, disp_src2_rdy,
        input  wake_valid, wake_preg,
        output disp_ready, fire_valid, sched_pkt, occupancy
    );
endinterface

// File: rtl/issue_scheduler.sv
// Out-of-order issue queue: tracks operand readiness via wakeup broadcasts
// and issues the oldest ready entry to register read each cycle.
module issue_scheduler #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PREG_W     = issue_scheduler_pkg::PREG_W,
    parameter int unsigned WAKE_PORTS = 2
) (
    input  logic            clk,
    input  logic            rst,
    issue_scheduler_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    typedef issue_scheduler_pkg::disp_packet_t pkt_t;
    typedef logic [PREG_W-1:0] tag_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] src1_rdy_q, src1_rdy_d;
    logic [DEPTH-1:0] src2_rdy_q, src2_rdy_d;
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    pkt_t             pkt_q [DEPTH];
    pkt_t             pkt_d [DEPTH];

    logic             fire_valid_q, fire_valid_d;
    pkt_t             sched_pkt_q, sched_pkt_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] winner;
    logic             has_win;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] free_idx;
    tag_t             sel_dst;
    logic             int_wake;
    logic             alloc;

    function automatic logic tag_hit(
        input tag_t                              tag,
        input logic [WAKE_PORTS-1:0]             wv,
        input logic [WAKE_PORTS-1:0][PREG_W-1:0] wp,
        input logic                              iw,
        input tag_t                              idst
    );
        logic hit;
        hit = iw && (tag == idst);
        for (int p = 0; p < int'(WAKE_PORTS); p++) begin
            hit = hit || (wv[p] && (wp[p] == tag));
        end
        return hit;
    endfunction

    // Oldest-ready select: an eligible entry wins when no eligible entry is older.
    always_comb begin
        eligible = valid_q & src1_rdy_q & src2_rdy_q;
        winner   = '0;
        win_idx  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            winner[i] = eligible[i] && ((age_q[i] & eligible) == '0);
            if (winner[i]) win_idx = IDX_W'(i);
        end
        has_win  = |winner;
        sel_dst  = tag_t'(pkt_q[win_idx].dst_preg);
        int_wake = has_win && (sel_dst != '0);
    end

    // Next-state: wakeup, free on fire, allocate, flush.
    always_comb begin
        alloc    = bus.disp_valid && bus.disp_ready && !bus.flush;
        free_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end

        valid_d    = valid_q & ~winner;
        src1_rdy_d = src1_rdy_q;
        src2_rdy_d = src2_rdy_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            pkt_d[i] = pkt_q[i];
            age_d[i] = age_q[i] & ~winner;
            if (valid_q[i]) begin
                src1_rdy_d[i] = src1_rdy_q[i] || tag_hit(tag_t'(pkt_q[i].src1_preg),
                                bus.wake_valid, bus.wake_preg, int_wake, sel_dst);
                src2_rdy_d[i] = src2_rdy_q[i] || tag_hit(tag_t'(pkt_q[i].src2_preg),
                                bus.wake_valid, bus.wake_preg, int_wake, sel_dst);
            end
        end

        // Dispatch sees same-cycle wakeups and the selected producer, so a
        // dependent of the issuing op can be picked on the very next cycle.
        if (alloc) begin
            valid_d[free_idx]    = 1'b1;
            pkt_d[free_idx]      = bus.disp_pkt;
            age_d[free_idx]      = valid_q & ~winner;
            src1_rdy_d[free_idx] = bus.disp_src1_rdy
                || (bus.disp_pkt.src1_preg == '0)
                || tag_hit(tag_t'(bus.disp_pkt.src1_preg), bus.wake_valid,
                           bus.wake_preg, has_win, sel_dst);
            src2_rdy_d[free_idx] = bus.disp_src2_rdy
                || (bus.disp_pkt.src2_preg == '0)
                || tag_hit(tag_t'(bus.disp_pkt.src2_preg), bus.wake_valid,
                           bus.wake_preg, has_win, sel_dst);
        end

        fire_valid_d = has_win;
        sched_pkt_d  = has_win ? pkt_q[win_idx] : sched_pkt_q;

        if (bus.flush) begin
            valid_d      = '0;
            fire_valid_d = 1'b0;
            sched_pkt_d  = sched_pkt_q;
        end

        occ_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= '0;
            src1_rdy_q   <= '0;
            src2_rdy_q   <= '0;
            fire_valid_q <= 1'b0;
            sched_pkt_q  <= '0;
            occ_q        <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                age_q[i] <= '0;
                pkt_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            src1_rdy_q   <= src1_rdy_d;
            src2_rdy_q   <= src2_rdy_d;
            fire_valid_q <= fire_valid_d;
            sched_pkt_q  <= sched_pkt_d;
            occ_q        <= occ_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                age_q[i] <= age_d[i];
                pkt_q[i] <= pkt_d[i];
            end
        end
    end

    assign bus.disp_ready = ~&valid_q;
    assign bus.fire_valid = fire_valid_q;
    assign bus.sched_pkt  = sched_pkt_q;
    assign bus.occupancy  = occ_q;

endmodule
